// File: rtl/mem_stage_sb.sv
// mem_stage_sb: pipeline memory stage with a posted store buffer draining to a handshaked data port.
// Build macro SB_FWD_EN enables full-coverage store-to-load forwarding from the youngest matching entry.
module mem_stage_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SB_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_write,
  input  logic                    mem_read,
  input  logic [1:0]              type_control,
  input  logic                    sign_ext_flag,
  input  logic [ADDR_WIDTH-1:0]   alu_result,
  input  logic [DATA_WIDTH-1:0]   write_data,
  output logic [ADDR_WIDTH-1:0]   alu_result_o,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    stall,
  output logic                    sb_empty,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [ADDR_WIDTH-1:0]   dmem_addr,
  output logic [DATA_WIDTH-1:0]   dmem_wdata,
  output logic [DATA_WIDTH/8-1:0] dmem_wstrb,
  input  logic                    dmem_ready,
  input  logic [DATA_WIDTH-1:0]   dmem_rdata
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int PTRW = $clog2(SB_DEPTH);
  localparam int CNTW = PTRW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD_REQ = 2'd1, LOAD_RESP = 2'd2} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sb_addr_q [SB_DEPTH];
  logic [DATA_WIDTH-1:0] sb_data_q [SB_DEPTH];
  logic [NB-1:0]         sb_strb_q [SB_DEPTH];
  logic [SB_DEPTH-1:0]   sb_valid_q;
  logic [PTRW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]       count_q;

  logic [1:0]            size_lg_s;
  logic [OFFW-1:0]       off_s;
  logic [NB-1:0]         acc_mask_s;
  logic [ADDR_WIDTH-1:0] line_addr_s;
  logic [DATA_WIDTH-1:0] st_data_s;
  logic                  hazard_s, fwd_hit_s, full_s;
  logic [DATA_WIDTH-1:0] fwd_data_s, ld_src_s;
  logic                  drain_en_s, pop_s, push_s, load_done_s;

  // Shift selected lanes down and extend from the access-size sign bit.
  function automatic logic [DATA_WIDTH-1:0] extract_lanes(input logic [DATA_WIDTH-1:0] src,
                                                          input logic [OFFW-1:0] off,
                                                          input logic [1:0] lg, input logic sext);
    logic [DATA_WIDTH-1:0] sh, ext;
    sh  = src >> {off, 3'b000};
    ext = sh;
    case (lg)
      2'd0: begin ext = {DATA_WIDTH{sext & sh[7]}};  ext[7:0]  = sh[7:0];  end
      2'd1: begin ext = {DATA_WIDTH{sext & sh[15]}}; ext[15:0] = sh[15:0]; end
      2'd2: begin ext = {DATA_WIDTH{sext & sh[31]}}; ext[31:0] = sh[31:0]; end
      default: ext = sh;
    endcase
    return ext;
  endfunction

  assign alu_result_o = alu_result;
  assign sb_empty     = (count_q == CNTW'(0));
  assign full_s       = (count_q == CNTW'(SB_DEPTH));
  assign line_addr_s  = alu_result & ~ADDR_WIDTH'(NB - 1);
  assign st_data_s    = write_data << {off_s, 3'b000};
  assign pop_s        = drain_en_s & dmem_ready;

  // Access size, size-masked lane offset and byte mask of the current access.
  always_comb begin
    case (type_control)
      2'b00:   size_lg_s = 2'd0;
      2'b01:   size_lg_s = 2'd1;
      2'b10:   size_lg_s = 2'd2;
      2'b11:   size_lg_s = (NB == 8) ? 2'd3 : 2'd2;
      default: size_lg_s = 2'd2;
    endcase
    for (int b = 0; b < OFFW; b++) off_s[b] = alu_result[b] & (b >= int'(size_lg_s));
    case (size_lg_s)
      2'd0:    acc_mask_s = NB'(1'b1) << off_s;
      2'd1:    acc_mask_s = NB'(2'b11) << off_s;
      2'd2:    acc_mask_s = NB'(4'hF) << off_s;
      default: acc_mask_s = {NB{1'b1}};
    endcase
  end

  // Overlap scan from oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [PTRW-1:0] idx;
    idx        = PTRW'(0);
    hazard_s   = 1'b0;
    fwd_hit_s  = 1'b0;
    fwd_data_s = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < SB_DEPTH; k++) begin
      idx = rd_ptr_q + PTRW'(k);
      if (sb_valid_q[idx] && (sb_addr_q[idx] == line_addr_s) &&
          ((sb_strb_q[idx] & acc_mask_s) != NB'(0))) begin
        hazard_s = 1'b1;
`ifdef SB_FWD_EN
        fwd_hit_s  = ((sb_strb_q[idx] & acc_mask_s) == acc_mask_s);
        fwd_data_s = sb_data_q[idx];
`endif
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  // Head entry may use the port whenever no load owns it.
  always_comb begin
    drain_en_s = 1'b0;
    if (rst_n && !sb_empty) begin
      case (state_q)
        IDLE:      drain_en_s = !(mem_read && !hazard_s);
        LOAD_RESP: drain_en_s = 1'b1;
        default:   drain_en_s = 1'b0;
      endcase
    end else begin
      drain_en_s = 1'b0;
    end
  end

  // Load FSM next state, store enqueue decision and port/result outputs.
  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    push_s      = 1'b0;
    load_done_s = 1'b0;
    ld_src_s    = dmem_rdata;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    dmem_addr   = {ADDR_WIDTH{1'b0}};
    dmem_wdata  = {DATA_WIDTH{1'b0}};
    dmem_wstrb  = {NB{1'b0}};
    if (!rst_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_read && !hazard_s) begin
            dmem_req  = 1'b1;
            dmem_addr = line_addr_s;
            stall     = 1'b1;
            state_d   = dmem_ready ? LOAD_RESP : LOAD_REQ;
          end else if (mem_read && fwd_hit_s) begin
            load_done_s = 1'b1;
            ld_src_s    = fwd_data_s;
          end else if (mem_read) begin
            stall = 1'b1;
          end else if (mem_write) begin
            push_s = !full_s || pop_s;
            stall  = full_s && !pop_s;
          end else begin
            stall = 1'b0;
          end
        end
        LOAD_REQ: begin
          dmem_req  = 1'b1;
          dmem_addr = line_addr_s;
          stall     = 1'b1;
          state_d   = dmem_ready ? LOAD_RESP : LOAD_REQ;
        end
        LOAD_RESP: begin
          load_done_s = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (drain_en_s) begin
        dmem_req   = 1'b1;
        dmem_we    = 1'b1;
        dmem_addr  = sb_addr_q[rd_ptr_q];
        dmem_wdata = sb_data_q[rd_ptr_q];
        dmem_wstrb = sb_strb_q[rd_ptr_q];
      end else begin
        dmem_we = 1'b0;
      end
    end
    read_data = load_done_s ? extract_lanes(ld_src_s, off_s, size_lg_s, sign_ext_flag)
                            : {DATA_WIDTH{1'b0}};
  end

  // FSM state and store-buffer FIFO storage; a full buffer may pop and push in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= PTRW'(0);
      rd_ptr_q   <= PTRW'(0);
      count_q    <= CNTW'(0);
      sb_valid_q <= {SB_DEPTH{1'b0}};
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_addr_q[i] <= {ADDR_WIDTH{1'b0}};
        sb_data_q[i] <= {DATA_WIDTH{1'b0}};
        sb_strb_q[i] <= {NB{1'b0}};
      end
    end else begin
      state_q <= state_d;
      if (pop_s) begin
        sb_valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q             <= rd_ptr_q + PTRW'(1);
      end
      if (push_s) begin
        sb_valid_q[wr_ptr_q] <= 1'b1;
        sb_addr_q[wr_ptr_q]  <= line_addr_s;
        sb_data_q[wr_ptr_q]  <= st_data_s;
        sb_strb_q[wr_ptr_q]  <= acc_mask_s;
        wr_ptr_q             <= wr_ptr_q + PTRW'(1);
      end
      count_q <= count_q + CNTW'(push_s) - CNTW'(pop_s);
    end
  end
endmodule

// File: tb/tb_mem_stage_sb.sv
// Directed bench for mem_stage_sb: load/store vector tables plus multi-cycle buffer/hazard/reset sequences.
module tb_mem_stage_sb;
  localparam int DW = 32, AW = 32, DEPTH = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic mem_write, mem_read, sign_ext_flag, stall, sb_empty, dmem_req, dmem_we, dmem_ready;
  logic [1:0] type_control;
  logic [AW-1:0] alu_result, alu_result_o, dmem_addr;
  logic [DW-1:0] write_data, read_data, dmem_wdata, dmem_rdata;
  logic [3:0] dmem_wstrb;

  always #5 clk = ~clk;

  mem_stage_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SB_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .mem_write(mem_write), .mem_read(mem_read),
    .type_control(type_control), .sign_ext_flag(sign_ext_flag), .alu_result(alu_result),
    .write_data(write_data), .alu_result_o(alu_result_o), .read_data(read_data), .stall(stall),
    .sb_empty(sb_empty), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata));

  // Data memory model: preloaded once during the first reset, byte-strobed writes.
  logic [31:0] mem [1024];
  logic loaded = 1'b0;
  int n_reads = 0, n_writes = 0;
  always @(posedge clk) begin
    if (!rst_n && !loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[32'h400 >> 2] <= 32'h80FF_0000;
      mem[32'h404 >> 2] <= 32'h1234_5678;
      loaded <= 1'b1;
    end else if (rst_n && dmem_req && dmem_ready) begin
      if (dmem_we) begin
        for (int b = 0; b < 4; b++)
          if (dmem_wstrb[b]) mem[dmem_addr[11:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
        n_writes <= n_writes + 1;
      end else begin
        dmem_rdata <= mem[dmem_addr[11:2]];
        n_reads    <= n_reads + 1;
      end
    end
  end

  int n_cmp = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] tc, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_read = rd; mem_write = wr; type_control = tc; sign_ext_flag = sx;
    alu_result = a; write_data = wd;
  endtask
  task automatic idle_in();
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
  endtask
  task automatic to_neg();
    @(negedge clk);
  endtask
  task automatic to_pos();
    @(posedge clk); #1;
  endtask

  typedef struct { logic [1:0] tc; logic sx; logic [31:0] addr; logic [31:0] exp_addr; logic [31:0] exp; } ld_vec_t;
  typedef struct { logic [1:0] tc; logic [31:0] addr; logic [31:0] wd; logic [31:0] exp_addr; logic [3:0] exp_strb; logic [31:0] exp_wdata; } st_vec_t;
  ld_vec_t lv [13];
  st_vec_t sv [5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int reads0, writes0;
    lv[0]  = '{2'b00, 1'b1, 32'h403, 32'h400, 32'hFFFF_FF80};
    lv[1]  = '{2'b00, 1'b0, 32'h403, 32'h400, 32'h0000_0080};
    lv[2]  = '{2'b01, 1'b1, 32'h402, 32'h400, 32'hFFFF_80FF};
    lv[3]  = '{2'b01, 1'b0, 32'h402, 32'h400, 32'h0000_80FF};
    lv[4]  = '{2'b01, 1'b1, 32'h400, 32'h400, 32'h0000_0000};
    lv[5]  = '{2'b10, 1'b1, 32'h400, 32'h400, 32'h80FF_0000};
    lv[6]  = '{2'b00, 1'b1, 32'h402, 32'h400, 32'hFFFF_FFFF};
    lv[7]  = '{2'b01, 1'b1, 32'h403, 32'h400, 32'hFFFF_80FF};
    lv[8]  = '{2'b10, 1'b1, 32'h401, 32'h400, 32'h80FF_0000};
    lv[9]  = '{2'b11, 1'b1, 32'h406, 32'h404, 32'h1234_5678};
    lv[10] = '{2'b00, 1'b1, 32'h405, 32'h404, 32'h0000_0056};
    lv[11] = '{2'b01, 1'b1, 32'h406, 32'h404, 32'h0000_1234};
    lv[12] = '{2'b00, 1'b0, 32'h404, 32'h404, 32'h0000_0078};
    sv[0] = '{2'b10, 32'h100, 32'hDEAD_BEEF, 32'h100, 4'b1111, 32'hDEAD_BEEF};
    sv[1] = '{2'b00, 32'h203, 32'h0000_00AA, 32'h200, 4'b1000, 32'hAA00_0000};
    sv[2] = '{2'b01, 32'h202, 32'h0000_BEEF, 32'h200, 4'b1100, 32'hBEEF_0000};
    sv[3] = '{2'b01, 32'h201, 32'h0000_1234, 32'h200, 4'b0011, 32'h0000_1234};
    sv[4] = '{2'b00, 32'h301, 32'h0000_0055, 32'h300, 4'b0010, 32'h0000_5500};

    // Reset state
    idle_in(); dmem_ready = 1'b0;
    repeat (3) @(posedge clk);
    to_neg();
    chk1("rst_stall", stall, 1'b0);     chk1("rst_req", dmem_req, 1'b0);
    chk1("rst_we", dmem_we, 1'b0);      chk("rst_wstrb", {28'h0, dmem_wstrb}, 32'h0);
    chk("rst_rdata", read_data, 32'h0); chk1("rst_empty", sb_empty, 1'b1);
    rst_n = 1'b1;
    to_pos();

    // Load table: one stall cycle with the read issued, result the following cycle
    for (int i = 0; i < 13; i++) begin
      dmem_ready = 1'b1;
      drive(1'b1, 1'b0, lv[i].tc, lv[i].sx, lv[i].addr, 32'h0);
      to_neg();
      chk1($sformatf("ld%0d_stall", i), stall, 1'b1);
      chk1($sformatf("ld%0d_req", i), dmem_req, 1'b1);
      chk1($sformatf("ld%0d_we", i), dmem_we, 1'b0);
      chk($sformatf("ld%0d_addr", i), dmem_addr, lv[i].exp_addr);
      chk($sformatf("ld%0d_pass", i), alu_result_o, lv[i].addr);
      to_pos();
      to_neg();
      chk1($sformatf("ld%0d_done_stall", i), stall, 1'b0);
      chk($sformatf("ld%0d_data", i), read_data, lv[i].exp);
      to_pos();
    end
    idle_in();

    // Store table: retire without stall, drain next cycle with lane-positioned data
    for (int i = 0; i < 5; i++) begin
      dmem_ready = 1'b1;
      drive(1'b0, 1'b1, sv[i].tc, 1'b0, sv[i].addr, sv[i].wd);
      to_neg();
      chk1($sformatf("st%0d_stall", i), stall, 1'b0);
      chk1($sformatf("st%0d_noreq", i), dmem_req, 1'b0);
      to_pos();
      idle_in();
      to_neg();
      chk1($sformatf("st%0d_req", i), dmem_req, 1'b1);
      chk1($sformatf("st%0d_we", i), dmem_we, 1'b1);
      chk($sformatf("st%0d_addr", i), dmem_addr, sv[i].exp_addr);
      chk($sformatf("st%0d_strb", i), {28'h0, dmem_wstrb}, {28'h0, sv[i].exp_strb});
      chk($sformatf("st%0d_wdata", i), dmem_wdata, sv[i].exp_wdata);
      to_pos();
      to_neg();
      chk1($sformatf("st%0d_empty", i), sb_empty, 1'b1);
      to_pos();
    end
    chk("mem_100", mem[32'h100 >> 2], 32'hDEAD_BEEF);
    chk("mem_200", mem[32'h200 >> 2], 32'hBEEF_1234);

    // Full buffer: DEPTH stores retire, next stalls until a drain is accepted
    dmem_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h500 + 32'(4 * i), 32'hA0 + 32'(i));
      to_neg();
      chk1($sformatf("fill%0d_stall", i), stall, 1'b0);
      to_pos();
    end
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h510, 32'hA4);
    to_neg();
    chk1("full_stall", stall, 1'b1);
    to_pos();
    to_neg();
    chk1("full_stall_hold", stall, 1'b1);
    dmem_ready = 1'b1;
    #1;
    chk1("full_pop_push_stall", stall, 1'b0);
    chk("full_head_addr", dmem_addr, 32'h500);
    to_pos();
    idle_in();
    to_neg();
    chk("full_next_addr", dmem_addr, 32'h504);
    chk1("full_not_empty", sb_empty, 1'b0);
    for (int k = 0; k < 20 && !sb_empty; k++) begin @(posedge clk); @(negedge clk); end
    chk1("full_drained", sb_empty, 1'b1);
    for (int i = 0; i < 5; i++)
      chk($sformatf("full_mem%0d", i), mem[(32'h500 >> 2) + i], 32'hA0 + 32'(i));
    to_pos();

    // Fully covered load after a buffered store
    dmem_ready = 1'b0;
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h200, 32'h1122_3344);
    to_neg(); chk1("fwd_st_stall", stall, 1'b0); to_pos();
    reads0 = n_reads;
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0);
    to_neg();
`ifdef SB_FWD_EN
    chk1("fwd_stall", stall, 1'b0);
    chk("fwd_data", read_data, 32'h0000_1122);
    chk1("fwd_port_is_drain", dmem_we, 1'b1);
    to_pos();
    idle_in(); dmem_ready = 1'b1;
    to_neg();
    for (int k = 0; k < 20 && !sb_empty; k++) begin @(posedge clk); @(negedge clk); end
    chk1("fwd_drained", sb_empty, 1'b1);
    chk("fwd_no_read", 32'(n_reads), 32'(reads0));
    to_pos();
`else
    chk1("haz_stall", stall, 1'b1);
    chk1("haz_drain_we", dmem_we, 1'b1);
    chk("haz_rdata_zero", read_data, 32'h0);
    to_pos(); to_neg();
    chk1("haz_stall_wait", stall, 1'b1);
    dmem_ready = 1'b1;
    #1;
    chk1("haz_stall_drain", stall, 1'b1);
    to_pos(); to_neg();
    chk1("haz_ld_stall", stall, 1'b1);
    chk1("haz_ld_we", dmem_we, 1'b0);
    chk("haz_ld_addr", dmem_addr, 32'h200);
    to_pos(); to_neg();
    chk1("haz_done_stall", stall, 1'b0);
    chk("haz_data", read_data, 32'h0000_1122);
    to_pos();
    idle_in();
    chk("haz_one_read", 32'(n_reads), 32'(reads0 + 1));
`endif

    // Partial overlap: always drains first, then reads memory
    dmem_ready = 1'b0;
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h300, 32'h0000_00AA);
    to_neg(); chk1("part_st_stall", stall, 1'b0); to_pos();
    reads0 = n_reads;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    to_neg();
    chk1("part_stall", stall, 1'b1);
    chk1("part_drain_we", dmem_we, 1'b1);
    dmem_ready = 1'b1;
    for (int k = 0; k < 20 && stall; k++) begin @(posedge clk); @(negedge clk); end
    chk1("part_done", stall, 1'b0);
    chk("part_data", read_data, 32'h0000_55AA);
    chk("part_one_read", 32'(n_reads), 32'(reads0 + 1));
    to_pos();
    idle_in();

    // Reset while a load waits in LOAD_REQ with two stores buffered
    dmem_ready = 1'b0;
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h600, 32'h1); to_neg(); to_pos();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h604, 32'h2); to_neg(); to_pos();
    writes0 = n_writes;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h700, 32'h0);
    to_neg();
    chk1("lr_issue_we", dmem_we, 1'b0);
    to_pos(); to_neg();
    chk1("lr_req", dmem_req, 1'b1);
    chk1("lr_stall", stall, 1'b1);
    chk1("lr_not_empty", sb_empty, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_req", dmem_req, 1'b0);
    chk1("mid_rst_empty", sb_empty, 1'b1);
    chk1("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_rdata", read_data, 32'h0);
    to_pos();
    idle_in(); dmem_ready = 1'b1; rst_n = 1'b1;
    repeat (3) to_pos();
    to_neg();
    chk1("post_rst_empty", sb_empty, 1'b1);
    chk1("post_rst_req", dmem_req, 1'b0);
    chk("post_rst_no_write", 32'(n_writes), 32'(writes0));
    to_pos();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage_sb.md
# mem_stage_sb

Parametrised pipeline memory stage with a posted store buffer. Stores retire in one cycle into an SB_DEPTH-entry FIFO that drains to a single-ported, handshaked data-memory port. Loads take priority on the port and perform byte/half/word(/double) lane extraction with optional sign extension. Sits between the EXE/MEM and MEM/WB pipeline registers; `stall` freezes upstream stages.

## Interface
- DATA_WIDTH, 32, datapath width; legal values 32 or 64; byte lanes NB = DATA_WIDTH/8
- ADDR_WIDTH, 32, address width
- SB_DEPTH, 4, store-buffer entries; power of two, ≥2
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_write  in  1  current instruction is a store
- mem_read  in  1  current instruction is a load (never together with mem_write)
- type_control  in  2  00 byte, 01 half, 10 word, 11 double (DATA_WIDTH=64) else word
- sign_ext_flag  in  1  1 = sign-extend load, 0 = zero-extend
- alu_result  in  ADDR_WIDTH  effective address
- write_data  in  DATA_WIDTH  store data, LSB-aligned
- alu_result_o  out  ADDR_WIDTH  combinational pass-through of alu_result
- read_data  out  DATA_WIDTH  extended load result; valid when load completes
- stall  out  1  hold current instruction and upstream stages
- sb_empty  out  1  store buffer empty
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write (drain), 0 = read (load)
- dmem_addr  out  ADDR_WIDTH  NB-aligned address
- dmem_wdata  out  DATA_WIDTH  lane-positioned write data
- dmem_wstrb  out  NB  byte strobes
- dmem_ready  in  1  request accepted this cycle when dmem_req=1
- dmem_rdata  in  DATA_WIDTH  read data, valid cycle after accepted read

## Operation
- Alignment: lane offset = alu_result[log2(NB)-1:0] masked to access size (half clears bit0, word clears [1:0], double clears [2:0]); misaligned access never faults.
- Store: build entry {NB-aligned addr, data shifted to lanes, strobes}; enqueue if not full, or if full and a drain is accepted same cycle. Otherwise stall=1.
- Drain: in IDLE with no load requesting the port, or in LOAD_RESP, head entry drives dmem_req=1, dmem_we=1; popped on dmem_ready.
- Load FSM, states IDLE, LOAD_REQ, LOAD_RESP:
  - IDLE, mem_read, no hazard: dmem_req=1, dmem_we=0, stall=1; dmem_ready → LOAD_RESP, else → LOAD_REQ.
  - LOAD_REQ: hold request, stall=1 until dmem_ready → LOAD_RESP.
  - LOAD_RESP: read_data = extract(dmem_rdata), stall=0, → IDLE.
- Hazard: any valid entry with equal NB-aligned address and strobes overlapping load bytes.
  - Full coverage by youngest matching entry and SB_FWD_EN defined: forward, read_data valid same cycle, stall=0, no memory read.
  - Otherwise: stall=1 while draining; load issues once no overlapping entry remains.
- Extraction: select lanes at offset; bit 7/15/31 extended per sign_ext_flag; double returns full width.
- read_data = 0 whenever no load completes.

## Timing
- Reset: all entries invalid, pointers/count 0, FSM IDLE; stall=0, dmem_req=0, dmem_we=0, dmem_wstrb=0, read_data=0, sb_empty=1. Reset mid-request discards the request and all buffered stores.
- Store hit (not full): 0 stall cycles. Full store: stall until a drain accepted.
- Load miss with dmem_ready=1: 1 stall cycle, completes in cycle 2. Each ready=0 cycle adds one.
- Forwarded load: 0 stall cycles.
- Simultaneous drain-pop and enqueue when full: count unchanged, no stall.
- FIFO pointers wrap modulo SB_DEPTH; entries drain strictly in order.

## Configuration
- SB_FWD_EN: defined → full-coverage store-to-load forwarding as above. Undefined → every hazard stalls until overlapping entries drain; forward mux and youngest-match logic absent.

## Test plan
- Reset then sw 0xDEADBEEF @0x100, ready=1 → stall=0; next cycle dmem_req=1, we=1, addr 0x100, wstrb 1111; sb_empty=1 after.
- lb @0x103 sign_ext=1, memory word 0x80FF_0000, ready=1 → stall 1 cycle, read_data 0xFFFFFF80; lbu → 0x00000080.
- ready=0 held; SB_DEPTH+1 stores → first SB_DEPTH retire, last stalls; ready=1 → pops and enqueues same cycle, stall drops.
- sw 0x11223344 @0x200 buffered, then lh @0x202 → with SB_FWD_EN read_data 0x00001122, no dmem read; without: stall until drain, then memory read.
- sb 0xAA @0x300 buffered, lw @0x300 (partial) → stall until drain, then read issued; read_data 0x......AA from memory.
- rst_n low during LOAD_REQ with 2 buffered stores → dmem_req=0 immediately, sb_empty=1, stall=0.
